// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // Fetch controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int          WORD_BYTES       = 4;
    localparam int          INST_W           = 32;
    localparam logic [31:0] DEFAULT_ROM_LAST = 32'd1020;

    // A queue entry is {instruction word, byte address}.
    localparam int          QUEUE_W          = 2 * INST_W;

    // A fetch address is legal when it is word aligned and inside the ROM.
    function automatic logic pc_is_legal(input logic [31:0] pc,
                                         input logic [31:0] rom_last);
        return (pc[1:0] == 2'b00) && (pc <= rom_last);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-decode handshake: head instruction, its address, valid/ready.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] inst_pc;

    // Fetch side drives the instruction, decode side drives ready.
    modport master (output inst_valid, output inst, output inst_pc, input inst_ready);
    modport slave  (input inst_valid, input inst, input inst_pc, output inst_ready);

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instruction, pc}; push and pop may share an edge,
// flush empties it. Head is read straight from the storage registers.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [QUEUE_W-1:0] push_data,
    output logic [1:0]         occupancy,
    output logic [QUEUE_W-1:0] head,
    output logic               valid
);

    logic [QUEUE_W-1:0] mem_reg [2];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         count_reg;

    logic               do_push;
    logic               do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && (count_reg != 2'd0) && !flush;

    // Storage write; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_reg[0] <= '0;
            mem_reg[1] <= '0;
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy; flush wins over any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign occupancy = count_reg;
    assign valid     = (count_reg != 2'd0);
    assign head      = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues ROM reads, queues the
// returned words and hands them to decode. Halts on an illegal address
// until redirected.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] ROM_LAST = DEFAULT_ROM_LAST
)(
    input  logic          clk,
    input  logic          rst_n,
    output logic [31:0]   rom_addr,
    output logic          rom_en,
    input  logic [31:0]   rom_data,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    instr_fetch_if.master dec,
    output logic          fault
);

    fetch_state_t state_reg;
    fetch_state_t state_next;

    logic [31:0]  pc_reg;
    logic         pending_reg;
    logic [31:0]  pending_pc_reg;
    logic         fault_reg;

    logic         pc_legal;
    logic         pop;
    logic         issue;
    logic         enter_halt;
    logic [2:0]   inflight;

    logic [1:0]         q_occupancy;
    logic [QUEUE_W-1:0] q_head;
    logic               q_valid;

    assign pc_legal = pc_is_legal(pc_reg, ROM_LAST);
    assign pop      = q_valid && dec.inst_ready;

    // Entries that will occupy the queue once the pending word lands;
    // pop only happens with a non-empty queue, so this never underflows.
    assign inflight = {1'b0, q_occupancy} + {2'b00, pending_reg} - {2'b00, pop};

    // Next-state and issue decision; redirect overrides everything.
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        enter_halt = 1'b0;
        if (redirect_valid) begin
            state_next = RUN;
        end else begin
            case (state_reg)
                IDLE: state_next = RUN;
                RUN: begin
                    if (!pc_legal) begin
                        state_next = HALT;
                        enter_halt = 1'b1;
                    end else if (inflight < 3'd2) begin
                        issue = 1'b1;
                    end
                end
                HALT:    state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // PC, in-flight tracking and fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg         <= RESET_PC;
            pending_reg    <= 1'b0;
            pending_pc_reg <= '0;
            fault_reg      <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg      <= redirect_pc;
            pending_reg <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            pending_reg <= issue;
            if (issue) begin
                pending_pc_reg <= pc_reg;
                pc_reg         <= pc_reg + 32'(WORD_BYTES);
            end
            if (enter_halt) begin
                fault_reg <= 1'b1;
            end
        end
    end

    // Words in flight on a redirect edge are dropped by the flush.
    fetch_queue u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pending_reg && !redirect_valid),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data ({rom_data, pending_pc_reg}),
        .occupancy (q_occupancy),
        .head      (q_head),
        .valid     (q_valid)
    );

    assign rom_addr       = pc_reg;
    assign rom_en         = issue;
    assign fault          = fault_reg;
    assign dec.inst_valid = q_valid;
    assign dec.inst       = q_head[QUEUE_W-1:INST_W];
    assign dec.inst_pc    = q_head[INST_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a byte-i-equals-i ROM model.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic        rom_en;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;

    int checks = 0;
    int errors = 0;

    instr_fetch_if dec_if ();

    instr_fetch #(.RESET_PC(32'd0), .ROM_LAST(32'd1020)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_en         (rom_en),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec_if),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: registered little-endian read where byte i holds i[7:0].
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] a1, a2, a3;
        a1 = a + 32'd1;
        a2 = a + 32'd2;
        a3 = a + 32'd3;
        return {a3[7:0], a2[7:0], a1[7:0], a[7:0]};
    endfunction

    initial rom_data = 32'd0;
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_word(rom_addr);
    end

    // An illegal address must never be presented with the read enable.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            assert (!(rom_en && ((rom_addr[1:0] != 2'b00) || (rom_addr > 32'd1020))))
            else begin
                errors++;
                $error("FAIL illegal_issue: observed rom_addr=0x%08h rom_en=%0b required no enable", rom_addr, rom_en);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] w, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(dec_if.inst_valid), 32'd1);
        chk({tag, "_inst"},  dec_if.inst,             w);
        chk({tag, "_pc"},    dec_if.inst_pc,          pc);
        $display("head %s: inst=0x%08h pc=0x%08h", tag, dec_if.inst, dec_if.inst_pc);
    endtask

    initial begin
        rst_n              = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = 32'd0;
        dec_if.inst_ready  = 1'b1;

        // Reset values
        #1;
        chk("rst_addr",  rom_addr, 32'd0);
        chk("rst_en",    32'(rom_en), 32'd0);
        chk("rst_valid", 32'(dec_if.inst_valid), 32'd0);
        chk("rst_inst",  dec_if.inst, 32'd0);
        chk("rst_pc",    dec_if.inst_pc, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Start-up latency and streaming
        tick();                                   // E0
        chk("e0_en",    32'(rom_en), 32'd1);
        chk("e0_addr",  rom_addr, 32'd0);
        chk("e0_valid", 32'(dec_if.inst_valid), 32'd0);
        tick();                                   // E1
        chk("e1_addr",  rom_addr, 32'd4);
        chk("e1_valid", 32'(dec_if.inst_valid), 32'd0);
        tick();                                   // E2
        chk_head("w0", 32'h03020100, 32'h0);
        tick();
        chk_head("w4", 32'h07060504, 32'h4);
        tick();
        chk_head("w8", 32'h0B0A0908, 32'h8);

        // Decode stall: queue fills, fetch stops with PC held
        dec_if.inst_ready = 1'b0;
        #1;
        chk("stall_en0",   32'(rom_en), 32'd0);
        chk("stall_addr0", rom_addr, 32'd16);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_en",   32'(rom_en), 32'd0);
            chk("stall_addr", rom_addr, 32'd16);
            chk_head("stall", 32'h0B0A0908, 32'h8);
        end
        dec_if.inst_ready = 1'b1;
        #1;
        chk("unstall_en",   32'(rom_en), 32'd1);
        chk("unstall_addr", rom_addr, 32'd16);
        tick();
        chk_head("w12", 32'h0F0E0D0C, 32'hC);
        tick();
        chk_head("w16", 32'h13121110, 32'h10);

        // Redirect to 0x40 with a word queued and one in flight
        dec_if.inst_ready = 1'b0;
        redirect_valid    = 1'b1;
        redirect_pc       = 32'h40;
        #1;
        chk("rd_cycle_en", 32'(rom_en), 32'd0);
        tick();                                   // R
        redirect_valid    = 1'b0;
        dec_if.inst_ready = 1'b1;
        #1;
        chk("rd_r_valid", 32'(dec_if.inst_valid), 32'd0);
        chk("rd_r_en",    32'(rom_en), 32'd1);
        chk("rd_r_addr",  rom_addr, 32'h40);
        tick();                                   // R+1
        chk("rd_r1_valid", 32'(dec_if.inst_valid), 32'd0);
        chk("rd_r1_addr",  rom_addr, 32'h44);
        tick();                                   // R+2
        chk_head("w40", 32'h43424140, 32'h40);

        // Misaligned redirect halts with fault
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3FE;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("mis_r_fault", 32'(fault), 32'd0);
        chk("mis_r_en",    32'(rom_en), 32'd0);
        chk("mis_r_valid", 32'(dec_if.inst_valid), 32'd0);
        tick();
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_en",    32'(rom_en), 32'd0);
        chk("mis_addr",  rom_addr, 32'h3FE);
        tick();
        chk("mis_fault2", 32'(fault), 32'd1);
        chk("mis_en2",    32'(rom_en), 32'd0);

        // Recovery redirect to 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rec_fault", 32'(fault), 32'd0);
        chk("rec_en",    32'(rom_en), 32'd1);
        chk("rec_addr",  rom_addr, 32'h0);
        tick();
        tick();
        chk_head("rec_w0", 32'h03020100, 32'h0);

        // Run off the end of the ROM
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3F4;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("end_en",   32'(rom_en), 32'd1);
        chk("end_addr", rom_addr, 32'h3F4);
        tick();
        tick();
        chk_head("w3f4", 32'hF7F6F5F4, 32'h3F4);
        tick();
        chk_head("w3f8", 32'hFBFAF9F8, 32'h3F8);
        chk("end_en_400",   32'(rom_en), 32'd0);
        chk("end_addr_400", rom_addr, 32'h400);
        chk("end_fault0",   32'(fault), 32'd0);
        tick();
        chk_head("w3fc", 32'hFFFEFDFC, 32'h3FC);
        chk("end_fault1", 32'(fault), 32'd1);
        tick();
        chk("end_drained", 32'(dec_if.inst_valid), 32'd0);
        chk("end_fault2",  32'(fault), 32'd1);
        chk("end_en2",     32'(rom_en), 32'd0);

        // Asynchronous reset mid-stream
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk_head("ar_w0", 32'h03020100, 32'h0);
        tick();
        chk_head("ar_w4", 32'h07060504, 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(dec_if.inst_valid), 32'd0);
        chk("ar_inst",  dec_if.inst, 32'd0);
        chk("ar_pc",    dec_if.inst_pc, 32'd0);
        chk("ar_en",    32'(rom_en), 32'd0);
        chk("ar_addr",  rom_addr, 32'd0);
        chk("ar_fault", 32'(fault), 32'd0);
        #7;
        rst_n = 1'b1;
        tick();                                   // E0
        chk("ar_e0_en",   32'(rom_en), 32'd1);
        chk("ar_e0_addr", rom_addr, 32'd0);
        tick();
        chk("ar_e1_valid", 32'(dec_if.inst_valid), 32'd0);
        tick();
        chk_head("ar_refetch", 32'h03020100, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
